// File: rtl/fir_sm_fifo.sv
// First-word-fall-through output FIFO for the FIR AXI-Stream master port.
// Define FIR_SM_FIFO_LAST_CHECK_EN to enable the tlast vs data_length frame check.
module fir_sm_fifo #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pDEPTH      = 16,
  parameter int unsigned pADDR_BITS  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic [pADDR_BITS:0]    level,
  input  logic [31:0]            data_length,
  output logic                   frame_done,
  output logic                   tlast_err,
  input  logic                   err_clr
);

  localparam int unsigned PTR_W = pADDR_BITS + 1;

  typedef struct packed {
    logic                   last;
    logic [pDATA_WIDTH-1:0] data;
  } beat_t;

  beat_t             mem [pDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full_nxt;
  beat_t             head;

  assign empty = (wr_ptr == rd_ptr);
  assign push  = s_tvalid & s_tready;
  assign pop   = m_tvalid & m_tready;

  assign wr_ptr_nxt = push ? PTR_W'(wr_ptr + PTR_W'(1)) : wr_ptr;
  assign rd_ptr_nxt = pop  ? PTR_W'(rd_ptr + PTR_W'(1)) : rd_ptr;
  assign full_nxt   = (wr_ptr_nxt[pADDR_BITS-1:0] == rd_ptr_nxt[pADDR_BITS-1:0]) &&
                      (wr_ptr_nxt[pADDR_BITS] != rd_ptr_nxt[pADDR_BITS]);

  // Pointers and ready flag; ready is registered so it never follows m_tready combinationally.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      s_tready <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      s_tready <= ~full_nxt;
    end
  end

  // Storage array carries no reset; contents are only observable behind m_tvalid.
  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem[wr_ptr[pADDR_BITS-1:0]] <= '{last: s_tlast, data: s_tdata};
    end
  end

  assign head     = mem[rd_ptr[pADDR_BITS-1:0]];
  assign m_tvalid = ~empty;
  assign m_tdata  = head.data;
  assign m_tlast  = head.last;
  assign level    = PTR_W'(wr_ptr - rd_ptr);

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= push & s_tlast;
    end
  end

`ifdef FIR_SM_FIFO_LAST_CHECK_EN
  logic [31:0] beat_cnt;
  logic [31:0] cnt_inc;
  logic        len_err;

  assign cnt_inc = 32'(beat_cnt + 32'd1);
  assign len_err = push && (data_length != 32'd0) &&
                   ((s_tlast && (cnt_inc != data_length)) ||
                    (!s_tlast && (cnt_inc == data_length)));

  // Frame beat counter and sticky mismatch flag; a new error outranks err_clr.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      beat_cnt  <= '0;
      tlast_err <= 1'b0;
    end else begin
      if (push) begin
        beat_cnt <= s_tlast ? 32'd0 : cnt_inc;
      end
      if (len_err) begin
        tlast_err <= 1'b1;
      end else if (err_clr) begin
        tlast_err <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{err_clr, data_length};
  assign tlast_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Scoreboard bench for fir_sm_fifo: accepted input beats are queued, a monitor pops and compares output beats.
module tb_fir_sm_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AB    = 4;

  logic          axis_clk;
  logic          axis_rst;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [AB:0]   level;
  logic [31:0]   data_length;
  logic          frame_done;
  logic          tlast_err;
  logic          err_clr;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int out_count = 0;
  logic [DW:0] exp_q [$];

  fir_sm_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pADDR_BITS(AB)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .level(level), .data_length(data_length), .frame_done(frame_done),
    .tlast_err(tlast_err), .err_clr(err_clr)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake is compared against the scoreboard head.
  always @(negedge axis_clk) begin
    if (!axis_rst) begin
      if (frame_done === 1'b1) fd_count++;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        checks++;
        out_count++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", {m_tlast, m_tdata});
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({m_tlast, m_tdata} !== e) begin
            errors++;
            $display("FAIL out_beat: got %0h expected %0h", {m_tlast, m_tdata}, e);
          end
        end
      end
    end
  end

  // Present one beat and hold it until accepted; expected value queued at acceptance.
  task automatic send(input logic [DW-1:0] d, input logic l);
    bit done;
    done = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge axis_clk);
      if (s_tready === 1'b1) begin
        exp_q.push_back({l, d});
        done = 1'b1;
      end
      @(posedge axis_clk);
      #1;
    end
    s_tvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_tready=0 expected 1");
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    m_tready = 1'b1;
    while ((exp_q.size() != 0 || level != 0) && t < 200) begin
      @(posedge axis_clk);
      #1;
      t++;
    end
    check({name, "_empty_level"}, 64'(level), 64'd0);
    check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    axis_rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    m_tready = 1'b0; data_length = 32'd600; err_clr = 1'b0;
    #1;
    check("rst_s_tready", 64'(s_tready), 64'd0);
    repeat (2) @(posedge axis_clk);
    #1 axis_rst = 1'b0;
    @(posedge axis_clk); #1;
    check("rst_s_tready_after", 64'(s_tready), 64'd1);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_tlast_err", 64'(tlast_err), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);

    // Pass-through: 600 beats, tlast on beat 600.
    fd_count = 0; out_count = 0; m_tready = 1'b1;
    for (int i = 1; i <= 600; i++) send(DW'(32'h8000_0000 ^ (i * 7)), (i == 600));
    drain("pass");
    check("pass_out_count", 64'(out_count), 64'd600);
    check("pass_frame_done", 64'(fd_count), 64'd1);
    check("pass_tlast_err", 64'(tlast_err), 64'd0);

    // Fill and back-pressure: 20 beats into a 16-deep FIFO.
    data_length = 32'd20; m_tready = 1'b0; out_count = 0;
    for (int i = 1; i <= 16; i++) send(DW'(i), 1'b0);
    @(posedge axis_clk); #1;
    check("fill_level", 64'(level), 64'd16);
    check("fill_s_tready", 64'(s_tready), 64'd0);
    check("fill_m_tvalid", 64'(m_tvalid), 64'd1);
    check("fill_head", 64'(m_tdata), 64'd1);
    @(posedge axis_clk); #1;
    check("fill_head_stable", 64'(m_tdata), 64'd1);
    m_tready = 1'b1;
    for (int i = 17; i <= 20; i++) send(DW'(i), (i == 20));
    drain("fill");
    check("fill_out_count", 64'(out_count), 64'd20);
    check("fill_tlast_err", 64'(tlast_err), 64'd0);

    // Simultaneous push/pop across pointer wrap, level held at 8.
    data_length = 32'd0; m_tready = 1'b0; out_count = 0;
    for (int i = 0; i < 8; i++) send(DW'(32'hA000 + i), 1'b0);
    check("simul_start_level", 64'(level), 64'd8);
    m_tready = 1'b1;
    for (int i = 8; i < 48; i++) begin
      send(DW'(32'hA000 + i), 1'b0);
      check("simul_level", 64'(level), 64'd8);
    end
    drain("simul");
    check("simul_out_count", 64'(out_count), 64'd48);

`ifdef FIR_SM_FIFO_LAST_CHECK_EN
    // Early tlast on beat 10 of an 11-beat frame.
    data_length = 32'd11;
    for (int i = 1; i <= 10; i++) send(DW'(-i), (i == 10));
    check("len_err_set", 64'(tlast_err), 64'd1);
    err_clr = 1'b1;
    @(posedge axis_clk); #1;
    err_clr = 1'b0;
    check("len_err_clr", 64'(tlast_err), 64'd0);
    for (int i = 1; i <= 11; i++) send(DW'(i * 3), (i == 11));
    check("len_ok_frame", 64'(tlast_err), 64'd0);
    drain("len");
`endif

    // Reset with 5 beats buffered.
    m_tready = 1'b0;
    for (int i = 1; i <= 5; i++) send(DW'(32'h5500 + i), 1'b0);
    check("mid_level", 64'(level), 64'd5);
    axis_rst = 1'b1;
    #1;
    check("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge axis_clk);
    #1 axis_rst = 1'b0;
    @(posedge axis_clk); #1;
    fd_count = 0; out_count = 0; data_length = 32'd4; m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) send(DW'(32'h7700 + i), (i == 4));
    drain("post_rst");
    check("post_rst_out_count", 64'(out_count), 64'd4);
    check("post_rst_frame_done", 64'(fd_count), 64'd1);
    check("post_rst_tlast_err", 64'(tlast_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
